// File: rtl/periodic_framer_sched.sv
// periodic_framer_sched: programs a periodic_framer for each burst command, arms it, then counts its frames.
// Optional feature macro FRAMER_SCHED_SKIP_UNCHANGED_EN: skip settings writes whose value matches the last one written.
module periodic_framer_sched #(
  parameter int BASE    = 0,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [63:0] cmd_tdata,
  input  logic        cmd_tvalid,
  output logic        cmd_tready,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data,
  output logic [31:0] trig_tdata,
  output logic        trig_tlast,
  output logic        trig_tvalid,
  input  logic        trig_tready,
  input  logic        frm_tvalid,
  input  logic        frm_tready,
  input  logic        frm_tlast,
  output logic        framer_clear,
  output logic        busy,
  output logic        done_stb,
  output logic        timeout_stb
);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_FRAME  = 3'd1,
    WR_GAP    = 3'd2,
    WR_OFFSET = 3'd3,
    WR_NSYM   = 3'd4,
    ARM       = 3'd5,
    RUN       = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [63:0]      cmd_r;
  logic [63:0]      cmd_cur;
  logic [3:0][15:0] fld;
  logic [3:0]       need;
  logic [15:0]      seq;
  logic [15:0]      cnt;
  logic [WDW-1:0]   wdog;
  logic             frame_end;
  logic             last_frame;
  logic             expire;
  logic             wr_nxt;
  logic [1:0]       wr_idx;
`ifdef FRAMER_SCHED_SKIP_UNCHANGED_EN
  logic [3:0][15:0] shadow;
`endif

  // WR_* state for the lowest pending field at or after index start; ARM when none remain.
  function automatic state_t first_wr(input logic [3:0] pend, input logic [2:0] start);
    first_wr = ARM;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i] && (3'(i) >= start)) first_wr = state_t'(3'(i + 1));
    end
  endfunction

  assign cmd_tready = (state == IDLE);
  assign trig_tdata = {16'd0, seq};

  // Next-state decode; fields come straight from the bus on the accept cycle.
  always_comb begin
    cmd_cur = cmd_r;
    if (state == IDLE) begin
      cmd_cur = cmd_tdata;
      if (cmd_tdata[63:48] < 16'd2) cmd_cur[63:48] = 16'd2;
      else cmd_cur[63:48] = cmd_tdata[63:48];
    end else begin
      cmd_cur = cmd_r;
    end
    fld = cmd_cur;
`ifdef FRAMER_SCHED_SKIP_UNCHANGED_EN
    for (int i = 0; i < 4; i++) need[i] = (fld[i] != shadow[i]);
`else
    need = 4'b1111;
`endif
    frame_end  = frm_tvalid & frm_tready & frm_tlast;
    last_frame = frame_end && ((cnt + 16'd1) == cmd_r[63:48]);
    expire     = (TIMEOUT != 0) && !frame_end && (wdog == WDW'(TIMEOUT - 1));
    state_nxt  = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (cmd_tvalid) state_nxt = first_wr(need, 3'd0); else state_nxt = IDLE;
        WR_FRAME,
        WR_GAP,
        WR_OFFSET,
        WR_NSYM:   state_nxt = first_wr(need, 3'(state));
        ARM:       if (trig_tready) state_nxt = RUN; else state_nxt = ARM;
        RUN:       if (last_frame || expire) state_nxt = IDLE; else state_nxt = RUN;
        default:   state_nxt = IDLE;
      endcase
    end
    wr_nxt = (state_nxt == WR_FRAME) || (state_nxt == WR_GAP) ||
             (state_nxt == WR_OFFSET) || (state_nxt == WR_NSYM);
    wr_idx = 2'(3'(state_nxt) - 3'd1);
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cmd_r        <= 64'd0;
      seq          <= 16'd0;
      cnt          <= 16'd0;
      wdog         <= '0;
      set_stb      <= 1'b0;
      set_addr     <= 8'd0;
      set_data     <= 32'd0;
      trig_tvalid  <= 1'b0;
      trig_tlast   <= 1'b0;
      busy         <= 1'b0;
      done_stb     <= 1'b0;
      timeout_stb  <= 1'b0;
      framer_clear <= 1'b0;
`ifdef FRAMER_SCHED_SKIP_UNCHANGED_EN
      shadow       <= '0;
`endif
    end else begin
      state        <= state_nxt;
      set_stb      <= wr_nxt;
      set_addr     <= wr_nxt ? (8'(BASE) + {6'd0, wr_idx}) : 8'd0;
      set_data     <= wr_nxt ? {16'd0, fld[wr_idx]} : 32'd0;
      trig_tvalid  <= (state_nxt == ARM) || (state_nxt == RUN);
      trig_tlast   <= (state_nxt == ARM);
      busy         <= (state_nxt != IDLE);
      done_stb     <= !clear && (state == RUN) && last_frame;
      timeout_stb  <= !clear && (state == RUN) && expire;
      framer_clear <= !clear && (state == RUN) && expire;
      if (!clear && (state == IDLE) && cmd_tvalid) cmd_r <= cmd_cur;
      if (clear) seq <= 16'd0;
      else if ((state == RUN) && (last_frame || expire)) seq <= seq + 16'd1;
      if (clear) cnt <= 16'd0;
      else if ((state == ARM) && trig_tready) cnt <= 16'd0;
      else if ((state == RUN) && frame_end) cnt <= cnt + 16'd1;
      // Watchdog restarts on RUN entry and on each frame-end.
      if ((state != RUN) || frame_end) wdog <= '0;
      else wdog <= wdog + WDW'(1);
`ifdef FRAMER_SCHED_SKIP_UNCHANGED_EN
      if (wr_nxt) shadow[wr_idx] <= fld[wr_idx];
`endif
    end
  end
endmodule
